four_input_nand_checker: RTL and testbench
==========================================

Name: four_input_nand_checker

Overview:
- Hardware response checker for the four-input NAND gate block; it is the receiving end of the exhaustive 16-vector stimulus sequence.
- Accepts each applied vector {a,b,c,d} through a valid/ready handshake and waits a programmable settle time.
- Then samples the gate outputs e, f, g and compares them against the golden truth table.
- Accumulates error count, first-failure index and vector coverage, and reports a single pass/fail at the end of the run.

Parameters:
- NUM_VECTORS, 16, vectors accepted per run before DONE (1..16).
- SETTLE_CYCLES, 2, clock cycles between vector acceptance and output sampling (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle pulse that begins a run; ignored unless in IDLE or DONE.
- vec_valid  input  1  stimulus side presents a new vector on a,b,c,d.
- vec_ready  output  1  checker can accept a vector.
- a, b, c, d  input  1 each  applied stimulus bits; a is the MSB of the vector index.
- e, f, g  input  1 each  DUT outputs under check.
- busy  output  1  run in progress (ARMED or SETTLE).
- done  output  1  run complete; held until the next start.
- pass  output  1  valid only while done=1.
- err_count  output  5  number of mismatching vectors, saturating at 31.
- first_fail_idx  output  4  index {a,b,c,d} of the first mismatching vector.
- first_fail_valid  output  1  first_fail_idx holds valid data.
- coverage  output  16  bit i set once vector index i has been checked.
- stim_err  output  1  sticky; a,b,c,d changed during SETTLE.

Behaviour:
- Golden model:
  - e_exp = ~(a&b)
  - f_exp = ~(c&d)
  - g_exp = ~(a&b&c&d)
  - A vector mismatches if any of e, f, g differs from its expected value.
- Reset (asynchronous, rst=1): state=IDLE; vec_ready=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, first_fail_valid=0, coverage=0, stim_err=0, internal counters=0.
- Reset asserted mid-run aborts immediately; there is no partial result.
- FSM states: IDLE, ARMED, SETTLE, DONE.
- IDLE:
  - All outputs at reset values.
  - start -> ARMED; err_count, coverage, first_fail_valid, stim_err and the vector counter are cleared on the same edge.
- ARMED:
  - vec_ready=1, busy=1.
  - On the edge with vec_valid&vec_ready: latch {a,b,c,d} into idx_q, load settle counter with SETTLE_CYCLES, go to SETTLE.
  - start is ignored.
- SETTLE:
  - vec_ready=0, busy=1.
  - The settle counter decrements every edge.
  - If {a,b,c,d} differs from idx_q on any edge in SETTLE, stim_err sets (sticky).
  - On the edge where the counter equals 1, sample e, f, g and compare using idx_q, not live inputs:
    - coverage[idx_q] is set.
    - On mismatch, err_count increments (saturating at 31).
    - On the first mismatch of the run, first_fail_idx=idx_q and first_fail_valid=1.
    - The vector counter increments; if it reaches NUM_VECTORS -> DONE, else -> ARMED.
  - Compare edge = acceptance edge + SETTLE_CYCLES. Results are visible on the cycle after the compare edge.
- DONE:
  - done=1, busy=0, vec_ready=0.
  - pass = (err_count==0) && (coverage==16'hFFFF) && !stim_err, computed combinationally from registered state.
  - With NUM_VECTORS<16, pass requires coverage of only the indices actually presented; the mask is the OR of accepted indices, and the rule is all accepted vectors matched, no stim_err, and no duplicate index.
  - start -> ARMED with counters cleared, as from IDLE.
- Duplicate vector index:
  - Counted toward NUM_VECTORS; coverage bit unchanged.
  - An internal dup flag is set, which forces pass=0.
- vec_valid outside ARMED is ignored; no acceptance occurs.

Test Plan:
- Correct DUT model, 16 vectors in ascending order 0000..1111, SETTLE_CYCLES=2 -> done after 16 accepts with 3 cycles per vector; err_count=0, coverage=16'hFFFF, pass=1, first_fail_valid=0.
- g forced wrong only for vector 1111 (g=1) -> err_count=1, first_fail_idx=4'hF, first_fail_valid=1, pass=0.
- f stuck at 1 -> mismatches only at indices 3,7,11,15; err_count=4, first_fail_idx=4'h3, pass=0.
- Vector 0101 presented twice and 1010 never presented -> coverage=16'hFBFF, pass=0, err_count=0.
- d toggled one cycle after acceptance of 0000 -> stim_err=1 persists through DONE, pass=0.
- rst pulsed after 7 vectors accepted, mid-SETTLE -> all outputs return to reset values the same cycle; a new start plus a full clean sequence -> pass=1.

Source files
------------

// File: rtl/four_input_nand_checker.sv
// four_input_nand_checker
// Response checker for a four-input NAND gate block. It accepts each applied
// vector {a,b,c,d} through a valid/ready handshake and waits SETTLE_CYCLES.
// It then samples the gate outputs e, f, g and compares them with the golden
// truth table. Across a run it accumulates the error count, the first failing
// index and the vector coverage. At the end of the run it reports pass/fail.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   start            one-cycle pulse that begins a run (honoured in IDLE/DONE)
//   vec_valid        stimulus side presents a vector on a,b,c,d
//   vec_ready        checker can accept a vector (ARMED)
//   a, b, c, d       applied stimulus bits, a is the MSB of the vector index
//   e, f, g          gate outputs under check
//   busy             run in progress (ARMED or SETTLE)
//   done             run complete, held until the next start
//   pass             run verdict, meaningful only while done=1
//   err_count        mismatching vectors, saturates at 31
//   first_fail_idx   index of the first mismatching vector
//   first_fail_valid first_fail_idx holds valid data
//   coverage         bit i set once vector index i has been checked
//   stim_err         sticky, a,b,c,d moved while a vector was settling
`timescale 1ns/1ps

module four_input_nand_checker #(
    parameter int NUM_VECTORS   = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        vec_valid,
    output logic        vec_ready,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_fail_idx,
    output logic        first_fail_valid,
    output logic [15:0] coverage,
    output logic        stim_err
);

    localparam int             SW          = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_CYCLES);
    localparam logic [4:0]     VEC_TOTAL   = 5'(NUM_VECTORS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Golden truth table of the gate block, returned as {e,f,g}.
    function automatic logic [2:0] golden_efg(input logic [3:0] idx);
        golden_efg = {~(idx[3] & idx[2]), ~(idx[1] & idx[0]), ~(&idx)};
    endfunction

    state_t        state_r;
    state_t        next_state_s;

    logic [3:0]    idx_q_r;
    logic [SW-1:0] settle_cnt_r;
    logic [4:0]    vec_cnt_r;
    logic [4:0]    err_count_r;
    logic [3:0]    first_fail_idx_r;
    logic          first_fail_valid_r;
    logic [15:0]   coverage_r;
    logic          stim_err_r;
    logic          dup_r;
    logic          vec_ready_r;
    logic          busy_r;
    logic          done_r;

    logic [3:0]    live_idx_s;
    logic          accept_s;
    logic          compare_s;
    logic          start_run_s;
    logic          last_vec_s;
    logic          mismatch_s;
    logic          cov_ok_s;

    assign live_idx_s = {a, b, c, d};
    // The comparison always uses the latched index, never the live inputs.
    assign mismatch_s = ({e, f, g} != golden_efg(idx_q_r));
    assign last_vec_s = ((vec_cnt_r + 5'd1) == VEC_TOTAL);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode plus the one-cycle event strobes used by the datapath.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        compare_s    = 1'b0;
        start_run_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    next_state_s = ARMED;
                    start_run_s  = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ARMED: begin
                if (vec_valid) begin
                    next_state_s = SETTLE;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ARMED;
                end
            end
            SETTLE: begin
                if (settle_cnt_r == SW'(1)) begin
                    compare_s = 1'b1;
                    if (last_vec_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = ARMED;
                    end
                end else begin
                    next_state_s = SETTLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Run datapath: vector latch, settle timer, scoreboard and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q_r            <= 4'd0;
            settle_cnt_r       <= {SW{1'b0}};
            vec_cnt_r          <= 5'd0;
            err_count_r        <= 5'd0;
            first_fail_idx_r   <= 4'd0;
            first_fail_valid_r <= 1'b0;
            coverage_r         <= 16'd0;
            stim_err_r         <= 1'b0;
            dup_r              <= 1'b0;
        end else if (start_run_s) begin
            err_count_r        <= 5'd0;
            coverage_r         <= 16'd0;
            first_fail_valid_r <= 1'b0;
            stim_err_r         <= 1'b0;
            dup_r              <= 1'b0;
            vec_cnt_r          <= 5'd0;
        end else if (accept_s) begin
            idx_q_r      <= live_idx_s;
            settle_cnt_r <= SETTLE_LOAD;
        end else if (state_r == SETTLE) begin
            settle_cnt_r <= settle_cnt_r - SW'(1);
            if (live_idx_s != idx_q_r) begin
                stim_err_r <= 1'b1;
            end
            if (compare_s) begin
                coverage_r[idx_q_r] <= 1'b1;
                // A repeated index still counts toward the run length but
                // leaves a hole elsewhere, so it poisons the verdict.
                if (coverage_r[idx_q_r]) begin
                    dup_r <= 1'b1;
                end
                if (mismatch_s) begin
                    if (err_count_r != 5'd31) begin
                        err_count_r <= err_count_r + 5'd1;
                    end
                    if (!first_fail_valid_r) begin
                        first_fail_idx_r   <= idx_q_r;
                        first_fail_valid_r <= 1'b1;
                    end
                end
                vec_cnt_r <= vec_cnt_r + 5'd1;
            end
        end
    end

    // Status outputs registered from the next state so they line up with state_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            vec_ready_r <= (next_state_s == ARMED);
            busy_r      <= (next_state_s == ARMED) || (next_state_s == SETTLE);
            done_r      <= (next_state_s == DONE);
        end
    end

    // A full run must cover every index. A shorter run only needs to cover the
    // indices it saw, and that requirement is already enforced by the dup flag.
    assign cov_ok_s = (NUM_VECTORS >= 16) ? (coverage_r == 16'hFFFF) : 1'b1;

    assign pass             = done_r && (err_count_r == 5'd0) && !stim_err_r && !dup_r && cov_ok_s;
    assign vec_ready        = vec_ready_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign err_count        = err_count_r;
    assign first_fail_idx   = first_fail_idx_r;
    assign first_fail_valid = first_fail_valid_r;
    assign coverage         = coverage_r;
    assign stim_err         = stim_err_r;

endmodule

// File: tb/tb_four_input_nand_checker.sv
`timescale 1ns/1ps

module tb_four_input_nand_checker;

    logic        clk = 1'b0;
    logic        rst, start, vec_valid;
    logic        a, b, c, d, e, f, g;
    logic        vec_ready, busy, done, pass;
    logic [4:0]  err_count;
    logic [3:0]  first_fail_idx;
    logic        first_fail_valid;
    logic [15:0] coverage;
    logic        stim_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] idx;
        logic [2:0] efg;
    } vec_t;

    vec_t       tbl[16];
    logic [3:0] seq_idx[16];
    logic [2:0] seq_efg[16];

    four_input_nand_checker #(.NUM_VECTORS(16), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
        .vec_ready(vec_ready), .a(a), .b(b), .c(c), .d(d),
        .e(e), .f(f), .g(g), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_idx(first_fail_idx),
        .first_fail_valid(first_fail_valid), .coverage(coverage),
        .stim_err(stim_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_vec_ready"}, vec_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_ffi"}, first_fail_idx, 0);
        chk({tag, "_ffv"}, first_fail_valid, 0);
        chk({tag, "_coverage"}, coverage, 0);
        chk({tag, "_stim_err"}, stim_err, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_ready", vec_ready, 1);
    endtask

    task automatic send(input logic [3:0] idx, input logic [2:0] efg, input bit toggle_d);
        int n;
        n = 0;
        while (!vec_ready && n < 20) begin
            tick();
            n++;
        end
        if (!vec_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: actual=vec_ready 0 required=1");
            return;
        end
        {a, b, c, d} = idx;
        {e, f, g}    = efg;
        vec_valid    = 1'b1;
        tick();
        vec_valid = 1'b0;
        chk("accept_ready_low", vec_ready, 0);
        n = 0;
        if (toggle_d) begin
            d = ~d;
            tick();
            n++;
            d = ~d;
        end
        while (!vec_ready && !done && n < 20) begin
            tick();
            n++;
        end
        chk("settle_latency", n, 2);
    endtask

    task automatic load_seq();
        for (int i = 0; i < 16; i++) begin
            seq_idx[i] = tbl[i].idx;
            seq_efg[i] = tbl[i].efg;
        end
    endtask

    task automatic run_seq(input int toggle_at);
        do_start();
        for (int i = 0; i < 16; i++) begin
            send(seq_idx[i], seq_efg[i], (i == toggle_at));
        end
    endtask

    initial begin
        logic [15:0] cov_exp;

        // Hand-computed truth table {a,b,c,d} -> {e,f,g}.
        tbl[0]  = '{4'h0, 3'b111};
        tbl[1]  = '{4'h1, 3'b111};
        tbl[2]  = '{4'h2, 3'b111};
        tbl[3]  = '{4'h3, 3'b101};
        tbl[4]  = '{4'h4, 3'b111};
        tbl[5]  = '{4'h5, 3'b111};
        tbl[6]  = '{4'h6, 3'b111};
        tbl[7]  = '{4'h7, 3'b101};
        tbl[8]  = '{4'h8, 3'b111};
        tbl[9]  = '{4'h9, 3'b111};
        tbl[10] = '{4'hA, 3'b111};
        tbl[11] = '{4'hB, 3'b101};
        tbl[12] = '{4'hC, 3'b011};
        tbl[13] = '{4'hD, 3'b011};
        tbl[14] = '{4'hE, 3'b011};
        tbl[15] = '{4'hF, 3'b000};

        rst = 1'b1; start = 1'b0; vec_valid = 1'b0;
        {a, b, c, d, e, f, g} = 7'd0;
        tick();
        tick();
        check_idle("in_reset");
        rst = 1'b0;
        tick();
        check_idle("after_reset");

        // vec_valid is ignored while IDLE.
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        chk("idle_valid_ready", vec_ready, 0);
        chk("idle_valid_busy", busy, 0);

        // Run 1: clean ascending sequence, coverage grows one bit per vector.
        do_start();
        cov_exp = 16'd0;
        for (int i = 0; i < 16; i++) begin
            send(tbl[i].idx, tbl[i].efg, 1'b0);
            cov_exp[i] = 1'b1;
            chk("r1_cov_step", coverage, cov_exp);
            chk("r1_err_step", err_count, 0);
        end
        chk("r1_done", done, 1);
        chk("r1_busy", busy, 0);
        chk("r1_ready", vec_ready, 0);
        chk("r1_pass", pass, 1);
        chk("r1_cov", coverage, 16'hFFFF);
        chk("r1_ffv", first_fail_valid, 0);
        tick();
        chk("r1_done_held", done, 1);

        // Run 2: g wrong only on 1111.
        load_seq();
        seq_efg[15] = 3'b001;
        run_seq(-1);
        chk("r2_done", done, 1);
        chk("r2_err", err_count, 1);
        chk("r2_ffi", first_fail_idx, 4'hF);
        chk("r2_ffv", first_fail_valid, 1);
        chk("r2_pass", pass, 0);

        // Run 3: f stuck at 1, mismatches at indices 3, 7, 11, 15.
        load_seq();
        for (int i = 0; i < 16; i++) seq_efg[i] = seq_efg[i] | 3'b010;
        run_seq(-1);
        chk("r3_err", err_count, 4);
        chk("r3_ffi", first_fail_idx, 4'h3);
        chk("r3_ffv", first_fail_valid, 1);
        chk("r3_pass", pass, 0);

        // Run 4: 0101 presented twice, 1010 never.
        load_seq();
        seq_idx[10] = 4'h5;
        seq_efg[10] = tbl[5].efg;
        run_seq(-1);
        chk("r4_done", done, 1);
        chk("r4_cov", coverage, 16'hFBFF);
        chk("r4_err", err_count, 0);
        chk("r4_ffv", first_fail_valid, 0);
        chk("r4_pass", pass, 0);

        // Run 5: d toggled during SETTLE of vector 0000.
        load_seq();
        run_seq(0);
        chk("r5_done", done, 1);
        chk("r5_stim_err", stim_err, 1);
        chk("r5_err", err_count, 0);
        chk("r5_cov", coverage, 16'hFFFF);
        chk("r5_pass", pass, 0);

        // Run 6: reset in the middle of SETTLE of the eighth vector.
        do_start();
        for (int i = 0; i < 7; i++) send(tbl[i].idx, tbl[i].efg, 1'b0);
        {a, b, c, d} = tbl[7].idx;
        {e, f, g}    = tbl[7].efg;
        vec_valid    = 1'b1;
        tick();
        vec_valid = 1'b0;
        chk("r6_mid_busy", busy, 1);
        tick();
        rst = 1'b1;
        #1;
        check_idle("r6_async_rst");
        rst = 1'b0;
        tick();
        check_idle("r6_after_rst");
        load_seq();
        run_seq(-1);
        chk("r6_done", done, 1);
        chk("r6_err", err_count, 0);
        chk("r6_cov", coverage, 16'hFFFF);
        chk("r6_stim_err", stim_err, 0);
        chk("r6_pass", pass, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
